// File: rtl/sram_port_arb.sv
// Two-port arbiter for a single-port SRAM. Port A is the core and is not buffered. Port B is the
// program loader: its full-word writes queue in a small FIFO and drain ahead of A when needed.
module sram_port_arb #(
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned MAX_WAIT   = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  // port A: core TL-UL adapter
  input  logic                    a_req_i,
  input  logic                    a_we_i,
  input  logic [ADDR_WIDTH-1:0]   a_addr_i,
  input  logic [DATA_WIDTH-1:0]   a_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] a_wmask_i,
  output logic                    a_gnt_o,
  output logic                    a_rvalid_o,
  output logic [DATA_WIDTH-1:0]   a_rdata_o,
  // port B: UART program loader
  input  logic                    b_valid_i,
  input  logic [ADDR_WIDTH-1:0]   b_addr_i,
  input  logic [DATA_WIDTH-1:0]   b_wdata_i,
  output logic                    b_ready_o,
  output logic                    b_idle_o,
  // SRAM macro
  output logic                    csb_o,
  output logic                    web_o,
  output logic [ADDR_WIDTH-1:0]   addr_o,
  output logic [DATA_WIDTH-1:0]   wdata_o,
  output logic [DATA_WIDTH/8-1:0] wmask_o,
  input  logic [DATA_WIDTH-1:0]   rdata_i
);

  localparam int unsigned MaskWidth = DATA_WIDTH / 8;
  localparam int unsigned PtrWidth  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntWidth  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned WaitWidth = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

  logic [ADDR_WIDTH-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
  logic [PtrWidth-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrWidth-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntWidth-1:0]   count_q, count_d;
  logic [WaitWidth-1:0]  wait_cnt_q, wait_cnt_d;
  logic                  a_rvalid_q, a_rvalid_d;

  logic fifo_full, fifo_empty;
  logic push, pop;
  logic b_win, a_win;

  assign fifo_full  = (count_q == CntWidth'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);

  // Readiness comes only from registered occupancy, so a full FIFO refuses a push even on a pop.
  assign b_ready_o = ~fifo_full;
  assign b_idle_o  = fifo_empty;
  assign push      = b_valid_i & ~fifo_full;

  assign b_win = ~fifo_empty &
                 (~a_req_i | fifo_full | (wait_cnt_q >= WaitWidth'(MAX_WAIT)));
  assign a_win = a_req_i & ~b_win;
  assign pop   = b_win;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Power-of-two depth lets the pointers wrap by natural overflow.
    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrWidth'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrWidth'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CntWidth'(1);
    end else if (pop && !push) begin
      count_d = count_q - CntWidth'(1);
    end
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (fifo_empty || b_win) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q < WaitWidth'(MAX_WAIT)) begin
      wait_cnt_d = wait_cnt_q + WaitWidth'(1);
    end
  end

  assign a_rvalid_d = a_win & ~a_we_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      wait_cnt_q <= '0;
      a_rvalid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      wait_cnt_q <= wait_cnt_d;
      a_rvalid_q <= a_rvalid_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= b_addr_i;
      fifo_data_q[wr_ptr_q] <= b_wdata_i;
    end
  end

  always_comb begin
    a_gnt_o = 1'b0;
    csb_o   = 1'b1;
    web_o   = 1'b1;
    addr_o  = '0;
    wdata_o = '0;
    wmask_o = '0;
    if (a_win) begin
      a_gnt_o = 1'b1;
      csb_o   = 1'b0;
      web_o   = ~a_we_i;
      addr_o  = a_addr_i;
      wdata_o = a_wdata_i;
      wmask_o = a_wmask_i;
    end else if (b_win) begin
      csb_o   = 1'b0;
      web_o   = 1'b0;
      addr_o  = fifo_addr_q[rd_ptr_q];
      wdata_o = fifo_data_q[rd_ptr_q];
      wmask_o = {MaskWidth{1'b1}};
    end
  end

  assign a_rvalid_o = a_rvalid_q;
  assign a_rdata_o  = a_rvalid_q ? rdata_i : '0;

endmodule

// File: tb/tb_sram_port_arb.sv
// Bench for sram_port_arb: directed scenarios plus randomized traffic, all checked against a
// queue-based model of the arbitration rules.
module tb_sram_port_arb;
  localparam int AW = 11;
  localparam int DW = 32;
  localparam int MW = DW / 8;
  localparam int DEPTH = 4;
  localparam int MAXW = 4;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          a_req_i = 1'b0, a_we_i = 1'b0;
  logic [AW-1:0] a_addr_i = '0;
  logic [DW-1:0] a_wdata_i = '0;
  logic [MW-1:0] a_wmask_i = '0;
  logic          a_gnt_o, a_rvalid_o;
  logic [DW-1:0] a_rdata_o;
  logic          b_valid_i = 1'b0;
  logic [AW-1:0] b_addr_i = '0;
  logic [DW-1:0] b_wdata_i = '0;
  logic          b_ready_o, b_idle_o, csb_o, web_o;
  logic [AW-1:0] addr_o;
  logic [DW-1:0] wdata_o;
  logic [MW-1:0] wmask_o;
  logic [DW-1:0] rdata_i = '0;

  sram_port_arb #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .MAX_WAIT(MAXW)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .a_req_i(a_req_i), .a_we_i(a_we_i), .a_addr_i(a_addr_i), .a_wdata_i(a_wdata_i),
    .a_wmask_i(a_wmask_i), .a_gnt_o(a_gnt_o), .a_rvalid_o(a_rvalid_o), .a_rdata_o(a_rdata_o),
    .b_valid_i(b_valid_i), .b_addr_i(b_addr_i), .b_wdata_i(b_wdata_i),
    .b_ready_o(b_ready_o), .b_idle_o(b_idle_o),
    .csb_o(csb_o), .web_o(web_o), .addr_o(addr_o), .wdata_o(wdata_o), .wmask_o(wmask_o),
    .rdata_i(rdata_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ent_t;

  // Reference state: buffered loader writes, cycles B has lost, and whether a read is in flight.
  ent_t q[$];
  int   wcnt = 0;
  bit   rv = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called just after a rising edge with inputs already driven; checks, then advances one clock.
  task automatic cycle();
    bit m_full, m_empty, m_bwin, m_awin;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic [MW-1:0] em;
    ent_t e;
    #1;
    m_full  = (q.size() == DEPTH);
    m_empty = (q.size() == 0);
    m_bwin  = !m_empty && (!a_req_i || m_full || wcnt >= MAXW);
    m_awin  = a_req_i && !m_bwin;
    ea = '0; ed = '0; em = '0;
    if (m_awin) begin
      ea = a_addr_i; ed = a_wdata_i; em = a_wmask_i;
    end else if (m_bwin) begin
      ea = q[0].addr; ed = q[0].data; em = '1;
    end
    check("a_gnt", a_gnt_o, m_awin);
    check("csb", csb_o, !(m_awin || m_bwin));
    check("web", web_o, m_awin ? !a_we_i : !m_bwin);
    check("addr", addr_o, ea);
    check("wdata", wdata_o, ed);
    check("wmask", wmask_o, em);
    check("b_ready", b_ready_o, !m_full);
    check("b_idle", b_idle_o, m_empty);
    check("a_rvalid", a_rvalid_o, rv);
    check("a_rdata", a_rdata_o, rv ? rdata_i : '0);
    @(posedge clk_i);
    if (m_bwin) q.delete(0);
    if (b_valid_i && !m_full) begin
      e.addr = b_addr_i;
      e.data = b_wdata_i;
      q.push_back(e);
    end
    wcnt = (m_empty || m_bwin) ? 0 : ((wcnt < MAXW) ? wcnt + 1 : MAXW);
    rv = m_awin && !a_we_i;
    #1;
  endtask

  task automatic quiet_inputs();
    a_req_i = 0; a_we_i = 0; a_addr_i = '0; a_wdata_i = '0; a_wmask_i = '0;
    b_valid_i = 0; b_addr_i = '0; b_wdata_i = '0;
  endtask

  task automatic apply_reset();
    rst_ni = 1'b0;
    quiet_inputs();
    #2;
    check("rst_b_ready", b_ready_o, 1);
    check("rst_b_idle", b_idle_o, 1);
    check("rst_a_gnt", a_gnt_o, 0);
    check("rst_csb", csb_o, 1);
    check("rst_web", web_o, 1);
    check("rst_a_rvalid", a_rvalid_o, 0);
    q.delete();
    wcnt = 0;
    rv = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    int found;
    int a_pct[4] = '{10, 90, 100, 60};
    int b_pct[4] = '{80, 70, 30, 50};

    apply_reset();

    // Idle: no access at all
    for (int i = 0; i < 3; i++) begin
      #1 check("idle_csb", csb_o, 1);
      cycle();
    end

    // Port A read, data returns next cycle
    a_req_i = 1; a_we_i = 0; a_addr_i = 11'h010; a_wmask_i = '1;
    #1 check("rd_gnt", a_gnt_o, 1);
    check("rd_addr", addr_o, 11'h010);
    cycle();
    a_req_i = 0;
    rdata_i = 32'hDEADBEEF;
    #1 check("rd_rvalid", a_rvalid_o, 1);
    check("rd_rdata", a_rdata_o, 32'hDEADBEEF);
    cycle();
    #1 check("rd_rvalid_clr", a_rvalid_o, 0);
    cycle();

    // Loader burst with A idle: writes drain in push order
    for (int i = 0; i < 6; i++) begin
      b_valid_i = (i < 4);
      b_addr_i  = AW'(11'h100 + i);
      b_wdata_i = 32'hA000_0000 + DW'(i);
      #1;
      if (i >= 1 && i <= 4) begin
        check("burst_web", web_o, 0);
        check("burst_wmask", wmask_o, 4'hF);
        check("burst_addr", addr_o, 11'h100 + i - 1);
        check("burst_wdata", wdata_o, 32'hA000_0000 + i - 1);
      end
      cycle();
    end
    #1 check("burst_idle", b_idle_o, 1);

    // Full FIFO with A hammering: B must win as soon as it fills
    a_req_i = 1; a_we_i = 1; a_addr_i = 11'h022; a_wdata_i = 32'h1234_5678; a_wmask_i = 4'h3;
    for (int i = 0; i < 5; i++) begin
      b_valid_i = (i < 4);
      b_addr_i  = AW'(11'h200 + i);
      b_wdata_i = 32'hB000_0000 + DW'(i);
      #1;
      if (i == 4) begin
        check("full_b_ready", b_ready_o, 0);
        check("full_a_gnt", a_gnt_o, 0);
        check("full_web", web_o, 0);
        check("full_addr", addr_o, 11'h200);
      end
      cycle();
    end
    quiet_inputs();
    for (int i = 0; i < 5; i++) cycle();

    // Starvation: a single entry behind a continuous A stream
    a_req_i = 1; a_we_i = 0; a_addr_i = 11'h033;
    found = -1;
    for (int c = 0; c < 20; c++) begin
      b_valid_i = (c == 0);
      b_addr_i  = 11'h3FF;
      b_wdata_i = 32'hCAFE_F00D;
      #1;
      if (found < 0 && !a_gnt_o) found = c;
      cycle();
    end
    check("starve_cycle", found, MAXW + 1);
    quiet_inputs();
    cycle();

    // Reset with three entries buffered and a read in flight
    a_req_i = 1; a_we_i = 0; a_addr_i = 11'h044;
    for (int i = 0; i < 3; i++) begin
      b_valid_i = 1;
      b_addr_i  = AW'(11'h300 + i);
      b_wdata_i = 32'hD000_0000 + DW'(i);
      cycle();
    end
    b_valid_i = 0;
    cycle();
    #1 check("pre_rst_count", b_idle_o, 0);
    check("pre_rst_rvalid", a_rvalid_o, 1);
    apply_reset();
    #1 check("post_rst_idle", b_idle_o, 1);
    check("post_rst_rvalid", a_rvalid_o, 0);
    check("post_rst_csb", csb_o, 1);
    cycle();

    // Randomized traffic across several contention mixes
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 600; i++) begin
        a_req_i   = ($urandom_range(99) < a_pct[p]);
        a_we_i    = $urandom_range(1);
        a_addr_i  = AW'($urandom);
        a_wdata_i = $urandom;
        a_wmask_i = MW'($urandom);
        b_valid_i = ($urandom_range(99) < b_pct[p]);
        b_addr_i  = AW'($urandom);
        b_wdata_i = $urandom;
        rdata_i   = $urandom;
        cycle();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
